fsub32_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision subtractor; computes Result = A - B. It is the subtract counterpart to the existing combinational FP adder.
- Handles the sign combinations the adder ignores: an effective subtract when the signs are equal, an effective add when they differ.
- Normalises left one bit per cycle.
- Sits beside the ALU in the multicycle datapath. The controller launches it with start and stalls until done.

---
 rtl/fsub32_seq_if.sv | 45 ++++
 rtl/fsub32_seq.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_fsub32_seq.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsub32_seq_if.sv
// -----------------------------------------------------------------------------
// fsub32_seq_if
//
// Purpose:
//   Handshake and data bundle between the multicycle controller (master) and
//   the sequential single-precision subtractor (slave).
//
// Signals:
//   start    master -> slave  launch request, sampled only while the unit idles
//   A        master -> slave  minuend, IEEE-754 single
//   B        master -> slave  subtrahend, IEEE-754 single
//   busy     slave -> master  operation in flight
//   done     slave -> master  one-cycle completion pulse
//   Result   slave -> master  A - B, held until the next accepted start
//   ALUFlags slave -> master  {N, Z, C, V}, held with Result
// -----------------------------------------------------------------------------
interface fsub32_seq_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] Result;
  logic [3:0]  ALUFlags;

  modport master (
    output start,
    output A,
    output B,
    input  busy,
    input  done,
    input  Result,
    input  ALUFlags
  );

  modport slave (
    input  start,
    input  A,
    input  B,
    output busy,
    output done,
    output Result,
    output ALUFlags
  );
endinterface

// File: rtl/fsub32_seq.sv
// -----------------------------------------------------------------------------
// fsub32_seq
//
// Purpose:
//   Multi-cycle IEEE-754 single-precision subtractor, Result = A - B.
//   Equal operand signs give an effective subtraction, differing signs an
//   effective addition. The smaller operand is aligned with a barrel shifter,
//   the difference is then normalised left by one bit per cycle. Rounding is
//   truncation and denormal operands are flushed to zero.
//
//   Sequence: IDLE -> ALIGN -> ADDSUB -> NORM (0..NORM_MAX cycles) -> DONE.
//   With start accepted in cycle 0, done pulses in cycle 3 + k where k is the
//   number of normalisation shifts.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset; aborts any operation in flight
//   bus    fsub32_seq_if.slave: start, A, B in; busy, done, Result, ALUFlags out
//
// Parameters:
//   NORM_MAX  safety bound on left-normalisation shifts before forcing +0
//
// Configuration macro:
//   FSUB32_SPECIALS_EN  when defined, ALIGN detects NaN / infinity operands and
//                       finishes in cycle 2 with the IEEE special result.
//                       When undefined, exponent 255 is an ordinary number.
// -----------------------------------------------------------------------------
module fsub32_seq #(
  parameter int NORM_MAX = 24
) (
  input  logic        clk,
  input  logic        reset,
  fsub32_seq_if.slave bus
);

  localparam int               CNT_W      = $clog2(NORM_MAX + 1);
  localparam logic [CNT_W-1:0] NORM_LIMIT = CNT_W'(NORM_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADDSUB,
    S_NORM,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t           state_q,   state_d;
  logic [31:0]      a_q,       a_d;
  logic [31:0]      b_q,       b_d;
  logic [23:0]      man_q,     man_d;
  logic [23:0]      small_q,   small_d;
  logic [7:0]       exp_q,     exp_d;
  logic             sign_q,    sign_d;
  logic             eff_sub_q, eff_sub_d;
  logic             c_q,       c_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [31:0]      result_q,  result_d;
  logic [3:0]       flags_q,   flags_d;

  // Completion strobe and the value that becomes Result on entry to DONE
  logic             finish;
  logic [31:0]      fin_result;
  logic             fin_v;

  // ---------------------------------------------------------------------------
  // Operand decode for ALIGN
  // ---------------------------------------------------------------------------
  logic [7:0]  exp_a, exp_b;
  logic [23:0] man_a, man_b;
  logic [30:0] mag_a, mag_b;
  logic        a_ge_b;
  logic [7:0]  big_exp;
  logic [7:0]  exp_diff;
  logic [23:0] big_man;
  logic [23:0] small_man;
  logic [23:0] small_aligned;

  assign exp_a = a_q[30:23];
  assign exp_b = b_q[30:23];

  // Exponent 0 is treated as zero regardless of fraction (denormals flushed)
  assign man_a = (exp_a == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
  assign man_b = (exp_b == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};

  // Magnitude keys use the flushed value so a denormal compares equal to zero
  assign mag_a = (exp_a == 8'd0) ? 31'd0 : a_q[30:0];
  assign mag_b = (exp_b == 8'd0) ? 31'd0 : b_q[30:0];

  assign a_ge_b    = (mag_a >= mag_b);
  assign big_exp   = a_ge_b ? exp_a : exp_b;
  assign exp_diff  = a_ge_b ? (exp_a - exp_b) : (exp_b - exp_a);
  assign big_man   = a_ge_b ? man_a : man_b;
  assign small_man = a_ge_b ? man_b : man_a;

  // Any difference of 25 or more pushes every mantissa bit out
  assign small_aligned = (exp_diff >= 8'd25) ? 24'd0 : (small_man >> exp_diff);

`ifdef FSUB32_SPECIALS_EN
  logic nan_a, nan_b, inf_a, inf_b;
  logic special_nan;

  assign nan_a = (exp_a == 8'hFF) && (a_q[22:0] != 23'd0);
  assign nan_b = (exp_b == 8'hFF) && (b_q[22:0] != 23'd0);
  assign inf_a = (exp_a == 8'hFF) && (a_q[22:0] == 23'd0);
  assign inf_b = (exp_b == 8'hFF) && (b_q[22:0] == 23'd0);

  // inf - inf with equal signs is the only invalid operation besides NaN input
  assign special_nan = nan_a || nan_b || (inf_a && inf_b && (a_q[31] == b_q[31]));
`endif

  // ---------------------------------------------------------------------------
  // ADDSUB / NORM arithmetic
  // ---------------------------------------------------------------------------
  logic [24:0] sum;
  logic [8:0]  exp_inc;
  logic [7:0]  exp_dec;

  // The larger magnitude is always in man_q, so the difference never wraps
  assign sum     = eff_sub_q ? ({1'b0, man_q} - {1'b0, small_q})
                             : ({1'b0, man_q} + {1'b0, small_q});
  assign exp_inc = {1'b0, exp_q} + 9'd1;
  assign exp_dec = exp_q - 8'd1;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    man_d      = man_q;
    small_d    = small_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    eff_sub_d  = eff_sub_q;
    c_d        = c_q;
    cnt_d      = cnt_q;
    finish     = 1'b0;
    fin_result = 32'd0;
    fin_v      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          state_d = S_ALIGN;
        end
      end

      S_ALIGN: begin
        man_d     = big_man;
        small_d   = small_aligned;
        exp_d     = big_exp;
        sign_d    = a_ge_b ? a_q[31] : ~b_q[31];
        eff_sub_d = (a_q[31] == b_q[31]);
        c_d       = a_ge_b;
        cnt_d     = '0;
        state_d   = S_ADDSUB;
`ifdef FSUB32_SPECIALS_EN
        if (special_nan) begin
          finish     = 1'b1;
          fin_result = 32'h7FC0_0000;
          fin_v      = 1'b1;
          state_d    = S_DONE;
        end else if (inf_a) begin
          finish     = 1'b1;
          fin_result = a_q;
          state_d    = S_DONE;
        end else if (inf_b) begin
          finish     = 1'b1;
          fin_result = {~b_q[31], b_q[30:0]};
          state_d    = S_DONE;
        end
`endif
      end

      S_ADDSUB: begin
        if (sum[24]) begin
          // Carry out of an effective add: renormalise right by one
          if (exp_inc >= 9'd255) begin
            finish     = 1'b1;
            fin_result = {sign_q, 8'hFF, 23'd0};
            fin_v      = 1'b1;
          end else begin
            man_d      = sum[24:1];
            exp_d      = exp_inc[7:0];
            finish     = 1'b1;
            fin_result = {sign_q, exp_inc[7:0], sum[23:1]};
          end
          state_d = S_DONE;
        end else if (sum[23:0] == 24'd0) begin
          // Exact cancellation always yields positive zero
          finish     = 1'b1;
          fin_result = 32'd0;
          state_d    = S_DONE;
        end else if (sum[23]) begin
          finish     = 1'b1;
          fin_result = {sign_q, exp_q, sum[22:0]};
          state_d    = S_DONE;
        end else begin
          man_d   = sum[23:0];
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        if ((exp_q <= 8'd1) || (cnt_q >= NORM_LIMIT)) begin
          // Underflow below the smallest normal exponent, or runaway bound hit
          finish     = 1'b1;
          fin_result = 32'd0;
          state_d    = S_DONE;
        end else begin
          man_d = {man_q[22:0], 1'b0};
          exp_d = exp_dec;
          cnt_d = cnt_q + CNT_W'(1);
          // Bit 22 becomes the hidden bit after this shift, so finish now
          if (man_q[22]) begin
            finish     = 1'b1;
            fin_result = {sign_q, exp_dec, man_q[21:0], 1'b0};
            state_d    = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Result and flags are loaded on the edge into DONE and then held
    result_d = result_q;
    flags_d  = flags_q;
    if (finish) begin
      result_d = fin_result;
      flags_d  = {fin_result[31], (fin_result[30:0] == 31'd0), c_d, fin_v};
    end
  end

  // ---------------------------------------------------------------------------
  // Register update with asynchronous active-low reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      man_q     <= 24'd0;
      small_q   <= 24'd0;
      exp_q     <= 8'd0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      result_q  <= 32'd0;
      flags_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      man_q     <= man_d;
      small_q   <= small_d;
      exp_q     <= exp_d;
      sign_q    <= sign_d;
      eff_sub_q <= eff_sub_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy     = (state_q == S_ALIGN) || (state_q == S_ADDSUB) || (state_q == S_NORM);
  assign bus.done     = (state_q == S_DONE);
  assign bus.Result   = result_q;
  assign bus.ALUFlags = flags_q;

endmodule

// File: tb/tb_fsub32_seq.sv
// -----------------------------------------------------------------------------
// tb_fsub32_seq
//
// Testbench for fsub32_seq. Expected results are pushed to a scoreboard queue
// when an operation is launched and popped when done pulses. Cycle numbering
// counts the cycle after the accepting edge as cycle 1.
// -----------------------------------------------------------------------------
module tb_fsub32_seq;

  logic clk;
  logic reset;

  fsub32_seq_if bus ();

  fsub32_seq #(.NORM_MAX(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  vec_t sb[$];
  int   checks;
  int   errors;

  // Waits for the unit to idle, pushes the expectation and pulses start
  task automatic launch(input vec_t v);
    @(negedge clk);
    for (int i = 0; i < 100 && (bus.busy || bus.done); i++) @(negedge clk);
    sb.push_back(v);
    bus.A     = v.a;
    bus.B     = v.b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Bounded wait for done; reports the cycle number it was seen in
  task automatic wait_done(output int cyc, output bit seen);
    cyc  = 1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  // Reset state of all outputs
  task automatic test_reset();
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    #2;
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0)      begin errors++; $display("[TB] FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.Result !== 32'd0)   begin errors++; $display("[TB] FAIL reset_result: got %h want 00000000", bus.Result); end
    checks++; if (bus.ALUFlags !== 4'd0)  begin errors++; $display("[TB] FAIL reset_flags: got %b want 0000", bus.ALUFlags); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Ordinary subtractions and effective additions
  task automatic test_arith();
    vec_t v[$];
    vec_t e;
    int   cyc;
    bit   seen;
    v.push_back('{"3m1",        32'h40400000, 32'h3F800000, 32'h40000000, 4'b0010, 3});
    v.push_back('{"1m1p5",      32'h3F800000, 32'h3FC00000, 32'hBF000000, 4'b1000, 4});
    v.push_back('{"1mneg1",     32'h3F800000, 32'hBF800000, 32'h40000000, 4'b0010, 3});
    v.push_back('{"0m1",        32'h00000000, 32'h3F800000, 32'hBF800000, 4'b1000, 3});
    v.push_back('{"neg1m2",     32'hBF800000, 32'h40000000, 32'hC0400000, 4'b1000, 3});
    v.push_back('{"diff25",     32'h3F800000, 32'h33000000, 32'h3F800000, 4'b0010, 3});
    v.push_back('{"diff23",     32'h3F800000, 32'h34000000, 32'h3F7FFFFE, 4'b0010, 4});
    v.push_back('{"norm23",     32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 4'b0010, 26});
    foreach (v[i]) begin
      launch(v[i]);
      wait_done(cyc, seen);
      e = sb.pop_front();
      checks++;
      if (!seen) begin
        errors++; $display("[TB] FAIL %s_done: no done pulse within bound", e.name);
      end else begin
        checks++; if (cyc !== e.lat)             begin errors++; $display("[TB] FAIL %s_latency: got %0d want %0d", e.name, cyc, e.lat); end
        checks++; if (bus.Result !== e.res)      begin errors++; $display("[TB] FAIL %s_result: got %h want %h", e.name, bus.Result, e.res); end
        checks++; if (bus.ALUFlags !== e.flags)  begin errors++; $display("[TB] FAIL %s_flags: got %b want %b", e.name, bus.ALUFlags, e.flags); end
      end
    end
  endtask

  // Cancellation, zeros, exponent underflow and overflow
  task automatic test_boundaries();
    vec_t v[$];
    vec_t e;
    int   cyc;
    bit   seen;
    v.push_back('{"1m1",        32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0110, 3});
    v.push_back('{"0m0",        32'h00000000, 32'h00000000, 32'h00000000, 4'b0110, 3});
    v.push_back('{"negz_m_z",   32'h80000000, 32'h00000000, 32'h00000000, 4'b0110, 3});
    v.push_back('{"underflow",  32'h00800001, 32'h00800000, 32'h00000000, 4'b0110, 4});
    v.push_back('{"overflow",   32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 4'b0011, 3});
    foreach (v[i]) begin
      launch(v[i]);
      wait_done(cyc, seen);
      e = sb.pop_front();
      checks++;
      if (!seen) begin
        errors++; $display("[TB] FAIL %s_done: no done pulse within bound", e.name);
      end else begin
        checks++; if (cyc !== e.lat)             begin errors++; $display("[TB] FAIL %s_latency: got %0d want %0d", e.name, cyc, e.lat); end
        checks++; if (bus.Result !== e.res)      begin errors++; $display("[TB] FAIL %s_result: got %h want %h", e.name, bus.Result, e.res); end
        checks++; if (bus.ALUFlags !== e.flags)  begin errors++; $display("[TB] FAIL %s_flags: got %b want %b", e.name, bus.ALUFlags, e.flags); end
      end
    end
  endtask

  // Consecutive operations; done is a single-cycle pulse and Result is held
  task automatic test_back_to_back();
    vec_t e;
    int   cyc;
    bit   seen;
    launch('{"b2b_first",  32'h3F800000, 32'hBF800000, 32'h40000000, 4'b0010, 3});
    wait_done(cyc, seen);
    e = sb.pop_front();
    checks++; if (!seen || bus.Result !== e.res) begin errors++; $display("[TB] FAIL %s_result: got %h want %h", e.name, bus.Result, e.res); end
    @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b0)     begin errors++; $display("[TB] FAIL b2b_pulse: done got %b want 0", bus.done); end
    checks++; if (bus.Result !== e.res)  begin errors++; $display("[TB] FAIL b2b_hold: got %h want %h", bus.Result, e.res); end
    launch('{"b2b_second", 32'h40000000, 32'h3F000000, 32'h3FC00000, 4'b0010, 4});
    wait_done(cyc, seen);
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++; $display("[TB] FAIL %s_done: no done pulse within bound", e.name);
    end else begin
      checks++; if (cyc !== e.lat)             begin errors++; $display("[TB] FAIL %s_latency: got %0d want %0d", e.name, cyc, e.lat); end
      checks++; if (bus.Result !== e.res)      begin errors++; $display("[TB] FAIL %s_result: got %h want %h", e.name, bus.Result, e.res); end
      checks++; if (bus.ALUFlags !== e.flags)  begin errors++; $display("[TB] FAIL %s_flags: got %b want %b", e.name, bus.ALUFlags, e.flags); end
    end
  endtask

  // start held high while busy and through DONE must be ignored
  task automatic test_ignore_start();
    vec_t e;
    int   cyc;
    bit   seen;
    int   extra_busy;
    int   extra_done;
    launch('{"ignore", 32'h40400000, 32'h3F800000, 32'h40000000, 4'b0010, 3});
    bus.A     = 32'h12345678;
    bus.B     = 32'hC1200000;
    bus.start = 1'b1;
    wait_done(cyc, seen);
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++; $display("[TB] FAIL %s_done: no done pulse within bound", e.name);
    end else begin
      checks++; if (cyc !== e.lat)             begin errors++; $display("[TB] FAIL %s_latency: got %0d want %0d", e.name, cyc, e.lat); end
      checks++; if (bus.Result !== e.res)      begin errors++; $display("[TB] FAIL %s_result: got %h want %h", e.name, bus.Result, e.res); end
      checks++; if (bus.ALUFlags !== e.flags)  begin errors++; $display("[TB] FAIL %s_flags: got %b want %b", e.name, bus.ALUFlags, e.flags); end
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
    extra_busy = 0;
    extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.busy === 1'b1) extra_busy++;
      if (bus.done === 1'b1) extra_done++;
      @(posedge clk);
      #1;
    end
    checks++; if (extra_busy !== 0)          begin errors++; $display("[TB] FAIL ignore_busy: busy cycles got %0d want 0", extra_busy); end
    checks++; if (extra_done !== 0)          begin errors++; $display("[TB] FAIL ignore_done: done cycles got %0d want 0", extra_done); end
    checks++; if (bus.Result !== 32'h40000000) begin errors++; $display("[TB] FAIL ignore_hold: got %h want 40000000", bus.Result); end
  endtask

  // Asynchronous reset during normalisation aborts without a done pulse
  task automatic test_reset_abort();
    int seen_done;
    @(negedge clk);
    for (int i = 0; i < 100 && (bus.busy || bus.done); i++) @(negedge clk);
    bus.A     = 32'h3F800000;
    bus.B     = 32'h3F7FFFFF;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checks++; if (bus.busy !== 1'b1)     begin errors++; $display("[TB] FAIL abort_busy_before: got %b want 1", bus.busy); end
    reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("[TB] FAIL abort_busy: got %b want 0", bus.busy); end
    checks++; if (bus.Result !== 32'd0)  begin errors++; $display("[TB] FAIL abort_result: got %h want 00000000", bus.Result); end
    checks++; if (bus.ALUFlags !== 4'd0) begin errors++; $display("[TB] FAIL abort_flags: got %b want 0000", bus.ALUFlags); end
    @(negedge clk);
    reset     = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
    end
    checks++; if (seen_done !== 0)       begin errors++; $display("[TB] FAIL abort_no_done: active cycles got %0d want 0", seen_done); end
  endtask

  // NaN / infinity operands; behaviour depends on FSUB32_SPECIALS_EN
  task automatic test_specials();
    vec_t v[$];
    vec_t e;
    int   cyc;
    bit   seen;
`ifdef FSUB32_SPECIALS_EN
    v.push_back('{"inf_m_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b0011, 2});
    v.push_back('{"1m_neginf", 32'h3F800000, 32'hFF800000, 32'h7F800000, 4'b0000, 2});
    v.push_back('{"nan_m_1",   32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0011, 2});
`else
    v.push_back('{"inf_m_inf", 32'h7F800000, 32'h7F800000, 32'h00000000, 4'b0110, 3});
    v.push_back('{"1m_neginf", 32'h3F800000, 32'hFF800000, 32'h7F800000, 4'b0000, 3});
    v.push_back('{"nan_m_1",   32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0010, 3});
`endif
    foreach (v[i]) begin
      launch(v[i]);
      wait_done(cyc, seen);
      e = sb.pop_front();
      checks++;
      if (!seen) begin
        errors++; $display("[TB] FAIL %s_done: no done pulse within bound", e.name);
      end else begin
        checks++; if (cyc !== e.lat)             begin errors++; $display("[TB] FAIL %s_latency: got %0d want %0d", e.name, cyc, e.lat); end
        checks++; if (bus.Result !== e.res)      begin errors++; $display("[TB] FAIL %s_result: got %h want %h", e.name, bus.Result, e.res); end
        checks++; if (bus.ALUFlags !== e.flags)  begin errors++; $display("[TB] FAIL %s_flags: got %b want %b", e.name, bus.ALUFlags, e.flags); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_arith();
    test_boundaries();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_specials();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
